// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: accepts a word over valid/ready, drives it onto a
// 2**SEL_W:1 mux, steps the mux select through every position, streams each
// returned bit out with backpressure, reassembles the bits and flags mismatches.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream word handshake, in_data = word
//   mux_data, mux_select    drive the external mux; mux_out is its output
//   bit_valid/bit_ready     serial bit handshake; bit_data = mux_out
//   bit_last                current bit is the final one of the word
//   capture_word, mismatch  reassembled word and compare flag, held until next word
//   word_done               one-cycle pulse after the last bit is accepted
module mux_scan_serializer #(
    parameter int SEL_W = 4,
    parameter bit LSB_FIRST = 1'b1,
    localparam int DATA_W = 2 ** SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_data,
    output logic [SEL_W-1:0]  mux_select,
    input  logic              mux_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_data,
    output logic              bit_last,
    output logic [DATA_W-1:0] capture_word,
    output logic              word_done,
    output logic              mismatch
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [SEL_W-1:0] START = LSB_FIRST ? SEL_W'(0) : SEL_W'(DATA_W - 1);
    localparam logic [SEL_W-1:0] STOP  = LSB_FIRST ? SEL_W'(DATA_W - 1) : SEL_W'(0);
    state_t state;
    logic [DATA_W-1:0] capture_next;
    assign in_ready  = state == IDLE;
    assign bit_valid = state == SCAN;
    assign word_done = state == DONE;
    assign bit_data  = mux_out;
    assign bit_last  = bit_valid && mux_select == STOP;
    always_comb begin
        capture_next = capture_word;
        capture_next[mux_select] = mux_out;
    end
    // mismatch is resolved on the last-bit edge from the final captured value,
    // so it is already valid during the word_done cycle and then simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mux_data     <= '0;
            mux_select   <= START;
            capture_word <= '0;
            mismatch     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mux_data     <= in_data;
                    mux_select   <= START;
                    capture_word <= '0;
                    mismatch     <= 1'b0;
                    state        <= SCAN;
                end
                SCAN: if (bit_ready) begin
                    capture_word <= capture_next;
                    if (bit_last) begin
                        mismatch <= capture_next != mux_data;
                        state    <= DONE;
                    end else begin
                        mux_select <= LSB_FIRST ? mux_select + SEL_W'(1) : mux_select - SEL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: two instances (LSB-first and MSB-first) driven through
// directed and randomized words, checked against a word-level reference model.
module tb_mux_scan_serializer;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid[2], in_ready[2], mux_out[2], bit_valid[2], bit_ready[2];
    logic bit_data[2], bit_last[2], word_done[2], mismatch[2], fault[2];
    logic [15:0] in_data[2], mux_data[2], capture_word[2];
    logic [3:0] mux_select[2];
    int checks = 0;
    int errors = 0;
    logic [15:0] stream;
    time hs_time;
    always #5 clk = ~clk;
    // behavioural 16:1 mux with an optional stuck-at-0 on input 3
    assign mux_out[0] = (fault[0] && mux_select[0] == 4'd3) ? 1'b0 : mux_data[0][mux_select[0]];
    assign mux_out[1] = (fault[1] && mux_select[1] == 4'd3) ? 1'b0 : mux_data[1][mux_select[1]];
    mux_scan_serializer #(.SEL_W(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .mux_data(mux_data[0]), .mux_select(mux_select[0]),
        .mux_out(mux_out[0]), .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]),
        .bit_data(bit_data[0]), .bit_last(bit_last[0]), .capture_word(capture_word[0]),
        .word_done(word_done[0]), .mismatch(mismatch[0]));
    mux_scan_serializer #(.SEL_W(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .mux_data(mux_data[1]), .mux_select(mux_select[1]),
        .mux_out(mux_out[1]), .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]),
        .bit_data(bit_data[1]), .bit_last(bit_last[1]), .capture_word(capture_word[1]),
        .word_done(word_done[1]), .mismatch(mismatch[1]));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic chk_reset();
        for (int u = 0; u < 2; u++) begin
            chk("rst_select", 16'(mux_select[u]), u == 0 ? 16'd0 : 16'd15);
            chk("rst_data", mux_data[u], 16'h0);
            chk("rst_capture", capture_word[u], 16'h0);
            chk("rst_flags", {12'h0, word_done[u], mismatch[u], bit_valid[u], in_ready[u]}, 16'h1);
        end
    endtask
    // Sends one word on instance u. stall_at: select index held off for 3 cycles.
    // abort_at: select index at which reset is asserted mid-word.
    task automatic send_word(input int u, input logic [15:0] w, input bit flt,
                             input int stall_at, input bit rnd, input int abort_at);
        logic [15:0] part = 16'h0;
        logic [15:0] exp_cap = flt ? (w & ~16'h0008) : w;
        int k = 0;
        int guard = 0;
        int stalls = 0;
        int idx;
        bit eb, br;
        fault[u] = flt;
        in_data[u] = w;
        in_valid[u] = 1'b1;
        chk("in_ready_idle", 16'(in_ready[u]), 16'd1);
        @(posedge clk);
        hs_time = $time;
        @(negedge clk);
        in_valid[u] = 1'b0;
        stream = 16'h0;
        while (k < 16 && guard < 200) begin
            idx = (u == 0) ? k : 15 - k;
            eb = (flt && idx == 3) ? 1'b0 : w[idx];
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset();
                bit_ready[u] = 1'b0;
                @(negedge clk);
                chk_reset();
                rst_n = 1'b1;
                return;
            end
            chk("bit_valid", 16'(bit_valid[u]), 16'd1);
            chk("in_ready_busy", 16'(in_ready[u]), 16'd0);
            chk("select", 16'(mux_select[u]), 16'(idx));
            chk("bit_data", 16'(bit_data[u]), 16'(eb));
            chk("bit_last", 16'(bit_last[u]), 16'(k == 15));
            chk("partial_capture", capture_word[u], part);
            chk("word_done_scan", 16'(word_done[u]), 16'd0);
            br = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx == stall_at && stalls < 3) begin
                br = 1'b0;
                stalls++;
            end
            bit_ready[u] = br;
            @(posedge clk);
            if (br) begin
                part[idx] = eb;
                stream = {stream[14:0], eb};
                k++;
            end
            @(negedge clk);
            guard++;
        end
        chk("scan_timeout", 16'(guard < 200), 16'd1);
        bit_ready[u] = 1'b0;
        chk("word_done", 16'(word_done[u]), 16'd1);
        chk("capture", capture_word[u], exp_cap);
        chk("mismatch", 16'(mismatch[u]), 16'(exp_cap != w));
        chk("done_flags", {14'h0, bit_valid[u], in_ready[u]}, 16'h0);
        @(negedge clk);
        chk("word_done_pulse", 16'(word_done[u]), 16'd0);
        chk("in_ready_back", 16'(in_ready[u]), 16'd1);
        chk("capture_hold", capture_word[u], exp_cap);
        chk("mismatch_hold", 16'(mismatch[u]), 16'(exp_cap != w));
        fault[u] = 1'b0;
    endtask
    initial begin
        time t1;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            bit_ready[u] = 1'b0;
            in_data[u] = 16'h0;
            fault[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        send_word(0, 16'hD3A7, 1'b0, -1, 1'b0, -1);
        chk("stream_lsb", stream, 16'b1110010111001011);
        send_word(1, 16'hD3A7, 1'b0, -1, 1'b0, -1);
        chk("stream_msb", stream, 16'b1101001110100111);
        send_word(0, 16'h5C3E, 1'b0, 5, 1'b0, -1);
        send_word(0, 16'hFFFF, 1'b1, -1, 1'b0, -1);
        send_word(0, 16'h0001, 1'b0, -1, 1'b0, -1);
        t1 = hs_time;
        send_word(0, 16'h8000, 1'b0, -1, 1'b0, -1);
        chk("back_to_back_cycles", 16'((hs_time - t1) / 10), 16'd18);
        send_word(0, 16'hA5F0, 1'b0, -1, 1'b0, 9);
        chk("no_done_after_abort", 16'(word_done[0]), 16'd0);
        @(negedge clk);
        send_word(0, 16'h3C96, 1'b0, -1, 1'b0, -1);
        for (int n = 0; n < 6; n++) begin
            send_word(n % 2, 16'($urandom), $urandom_range(0, 1) == 1, -1, 1'b1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
